// File: rtl/pingpong_stream_buffer.sv
// Double-buffered frame buffer: captures a whole frame per save and streams it out one word at a time.
// Optional dropped-save counter output enabled with `define PINGPONG_DROP_CNT_EN.
module pingpong_stream_buffer #(
  parameter int DATA_W    = 16,
  parameter int NUM_WORDS = 120,
  parameter int ADDR_W    = $clog2(NUM_WORDS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_W*NUM_WORDS-1:0] din,
  input  logic                        save,
  output logic                        save_ready,
  output logic signed [DATA_W-1:0]    dout,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic [ADDR_W-1:0]           addr,
  output logic                        frame_last,
  output logic                        busy
`ifdef PINGPONG_DROP_CNT_EN
  ,
  output logic [15:0]                 drop_cnt
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  logic signed [DATA_W-1:0] mem_q [2][NUM_WORDS];

  logic [1:0]               state_q, state_d;
  logic [1:0]               full_q, full_d;
  logic                     wr_bank_q, wr_bank_d;
  logic                     rd_bank_q, rd_bank_d;
  logic signed [DATA_W-1:0] dout_q, dout_d;
  logic                     dout_valid_q, dout_valid_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic                     frame_last_q, frame_last_d;
  logic [ADDR_W-1:0]        addr_nxt;
  logic                     save_acc;
  logic                     rd_acc;

  assign save_acc = save && !full_q[wr_bank_q];
  assign rd_acc   = dout_valid_q && dout_ready;
  assign addr_nxt = addr_q + 1'b1;

  // Bank storage is deliberately left out of reset; all words land in one edge.
  always_ff @(posedge clk) begin
    if (save_acc) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        mem_q[wr_bank_q][k] <= din[DATA_W*(NUM_WORDS-k)-1 -: DATA_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    full_d       = full_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    addr_d       = addr_q;
    frame_last_d = frame_last_q;

    if (save_acc) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end

    case (state_q)
      S_IDLE: begin
        if (full_q[rd_bank_q]) state_d = S_LOAD;
      end
      S_LOAD: begin
        dout_d       = mem_q[rd_bank_q][0];
        addr_d       = '0;
        dout_valid_d = 1'b1;
        frame_last_d = 1'b0;
        state_d      = S_STREAM;
      end
      S_STREAM: begin
        if (rd_acc) begin
          if (frame_last_q) begin
            // A save can never target rd_bank here, so clearing its flag cannot race a capture.
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            addr_d            = '0;
            frame_last_d      = 1'b0;
            if (full_q[~rd_bank_q]) begin
              dout_d = mem_q[~rd_bank_q][0];
            end else begin
              dout_d       = '0;
              dout_valid_d = 1'b0;
              state_d      = S_IDLE;
            end
          end else begin
            dout_d       = mem_q[rd_bank_q][addr_nxt];
            addr_d       = addr_nxt;
            frame_last_d = (addr_nxt == LAST_ADDR);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      full_q       <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      addr_q       <= '0;
      frame_last_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      full_q       <= full_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      addr_q       <= addr_d;
      frame_last_q <= frame_last_d;
    end
  end

  assign save_ready = !full_q[wr_bank_q];
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign addr       = addr_q;
  assign frame_last = frame_last_q;
  assign busy       = full_q[0] | full_q[1] | (state_q == S_STREAM);

`ifdef PINGPONG_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (save && !save_ready && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pingpong_stream_buffer.sv
// Directed self-checking bench for pingpong_stream_buffer (DATA_W=16, NUM_WORDS=120).
module tb_pingpong_stream_buffer;
  localparam int DATA_W    = 16;
  localparam int NUM_WORDS = 120;
  localparam int ADDR_W    = $clog2(NUM_WORDS);

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic [DATA_W*NUM_WORDS-1:0] din;
  logic                        save;
  logic                        save_ready;
  logic signed [DATA_W-1:0]    dout;
  logic                        dout_valid;
  logic                        dout_ready;
  logic [ADDR_W-1:0]           addr;
  logic                        frame_last;
  logic                        busy;
`ifdef PINGPONG_DROP_CNT_EN
  logic [15:0]                 drop_cnt;
`endif

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pingpong_stream_buffer #(.DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .save(save), .save_ready(save_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .addr(addr),
    .frame_last(frame_last), .busy(busy)
`ifdef PINGPONG_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input logic [15:0] base);
    for (int k = 0; k < NUM_WORDS; k++) begin
      din[DATA_W*(NUM_WORDS-k)-1 -: DATA_W] = 16'(base + k);
    end
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!dout_valid && n < max) begin
      tick();
      n++;
    end
    chk("wait_valid", {31'd0, dout_valid}, 32'd1);
  endtask

  // Receives words first..first+n-1 of a frame; a stalled cycle re-checks the same word.
  task automatic recv(input logic [15:0] base, input int first, input int n, input bit rnd);
    for (int i = first; i < first + n; i++) begin
      int st = 0;
      forever begin
        if (rnd && st < 8) dout_ready = 1'($urandom_range(0, 1));
        else               dout_ready = 1'b1;
        chk("valid", {31'd0, dout_valid}, 32'd1);
        chk("dout", {16'd0, $unsigned(dout)}, {16'd0, 16'(base + i)});
        chk("addr", {25'd0, addr}, i);
        chk("last", {31'd0, frame_last}, {31'd0, (i == NUM_WORDS - 1)});
        if (rnd) chk("sign", {31'd0, dout[15]}, {31'd0, base[15]});
        tick();
        if (dout_ready) break;
        st++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; save = 1'b0; din = '0; dout_ready = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_dout", {16'd0, $unsigned(dout)}, 32'd0);
    chk("rst_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_addr", {25'd0, addr}, 32'd0);
    chk("rst_last", {31'd0, frame_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_save_ready", {31'd0, save_ready}, 32'd1);

    // Single frame, exact two-cycle latency
    load_frame(16'd1); save = 1'b1; dout_ready = 1'b1;
    tick();
    save = 1'b0;
    chk("lat_t0", {31'd0, dout_valid}, 32'd0);
    chk("busy_after_save", {31'd0, busy}, 32'd1);
    tick();
    chk("lat_t1", {31'd0, dout_valid}, 32'd0);
    tick();
    chk("lat_t2", {31'd0, dout_valid}, 32'd1);
    recv(16'd1, 0, NUM_WORDS, 1'b0);
    chk("f1_end_valid", {31'd0, dout_valid}, 32'd0);
    chk("f1_end_busy", {31'd0, busy}, 32'd0);

    // Back-to-back frames stream with no gap
    load_frame(16'h0A00); save = 1'b1;
    tick();
    load_frame(16'h0B00);
    tick();
    save = 1'b0;
    wait_valid(10);
    recv(16'h0A00, 0, NUM_WORDS, 1'b0);
    recv(16'h0B00, 0, NUM_WORDS, 1'b0);
    chk("b2b_end_valid", {31'd0, dout_valid}, 32'd0);

    // Overrun: third save dropped while consumer stalls
    tick();
    dout_ready = 1'b0;
    load_frame(16'h0A00); save = 1'b1;
    tick();
    chk("ovr_ready1", {31'd0, save_ready}, 32'd1);
    load_frame(16'h0B00);
    tick();
    chk("ovr_ready2", {31'd0, save_ready}, 32'd0);
    load_frame(16'h0C00);
    tick();
    save = 1'b0;
    chk("ovr_ready3", {31'd0, save_ready}, 32'd0);
`ifdef PINGPONG_DROP_CNT_EN
    chk("drop_cnt", {16'd0, drop_cnt}, 32'd1);
`endif
    for (int s = 0; s < 3; s++) begin
      chk("ovr_hold_valid", {31'd0, dout_valid}, 32'd1);
      chk("ovr_hold_dout", {16'd0, $unsigned(dout)}, 32'h0A00);
      chk("ovr_hold_addr", {25'd0, addr}, 32'd0);
      tick();
    end
    recv(16'h0A00, 0, NUM_WORDS, 1'b0);
    recv(16'h0B00, 0, NUM_WORDS, 1'b0);
    for (int s = 0; s < 4; s++) begin
      chk("ovr_no_c", {31'd0, dout_valid}, 32'd0);
      tick();
    end
    chk("ovr_busy", {31'd0, busy}, 32'd0);
    chk("ovr_ready_back", {31'd0, save_ready}, 32'd1);

    // Random back-pressure with negative words
    load_frame(16'h8000); save = 1'b1;
    tick();
    save = 1'b0;
    wait_valid(10);
    recv(16'h8000, 0, NUM_WORDS, 1'b1);
    chk("rnd_end_valid", {31'd0, dout_valid}, 32'd0);

    // Reset mid-stream with second bank full
    load_frame(16'h0100); save = 1'b1;
    tick();
    load_frame(16'h0200);
    tick();
    save = 1'b0;
    wait_valid(10);
    recv(16'h0100, 0, 57, 1'b0);
    chk("mid_addr57", {25'd0, addr}, 32'd57);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dout", {16'd0, $unsigned(dout)}, 32'd0);
    chk("arst_valid", {31'd0, dout_valid}, 32'd0);
    chk("arst_addr", {25'd0, addr}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_ready", {31'd0, save_ready}, 32'd1);
    for (int s = 0; s < 6; s++) begin
      chk("no_stale", {31'd0, dout_valid}, 32'd0);
      tick();
    end
    load_frame(16'h0300); save = 1'b1;
    tick();
    save = 1'b0;
    wait_valid(10);
    recv(16'h0300, 0, NUM_WORDS - 1, 1'b0);

    // Save coincident with last-word accept
    load_frame(16'h0400); save = 1'b1;
    chk("coin_last", {31'd0, frame_last}, 32'd1);
    chk("coin_dout", {16'd0, $unsigned(dout)}, 32'h0300 + NUM_WORDS - 1);
    tick();
    save = 1'b0;
    chk("coin_valid_drop", {31'd0, dout_valid}, 32'd0);
    chk("coin_busy", {31'd0, busy}, 32'd1);
    wait_valid(10);
    recv(16'h0400, 0, NUM_WORDS, 1'b0);
    chk("coin_end_valid", {31'd0, dout_valid}, 32'd0);
    chk("coin_end_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
